// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the 5-stage pipeline front end.
// Sequences load-use stalls, taken-branch/jump flushes and multi-cycle
// mult/div occupancy. Outputs are combinational from registered state plus
// the current cycle's hazard inputs.
// Optional feature: define HAZARD_PERF_EN to add the stall_cycles and
// flush_count performance counter ports.
module hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MULDIV_CYCLES     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_isMulDiv,
    input  logic       ID_useHiLo,
    input  logic       EX_memRead,
    input  logic [4:0] EX_rt,
    input  logic       EX_flush,
    output logic       pc_write,
    output logic       IF_ID_sleep,
    output logic       IF_ID_nop,
    output logic       ID_EX_nop,
    output logic       md_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LD_STALL = 2'd1;
    localparam logic [1:0] ST_MD_WAIT  = 2'd2;

    localparam logic [1:0] ACT_NONE  = 2'd0;
    localparam logic [1:0] ACT_STALL = 2'd1;
    localparam logic [1:0] ACT_FLUSH = 2'd2;

    // The load-use cycle itself is the first bubble, so LD_STALL covers the rest.
    localparam logic [7:0] LD_CNT_INIT = 8'(LOAD_STALL_CYCLES - 1);
    localparam logic [7:0] MD_CNT_INIT = 8'(MULDIV_CYCLES);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic [1:0] act;
    logic       lu_hit;

    assign lu_hit = EX_memRead && (EX_rt != 5'd0) &&
                    ((EX_rt == ID_rs) || (EX_rt == ID_rt));

    // Next-state, counter and per-cycle action; priority is flush > mult/div > load-use.
    always_comb begin
        act       = ACT_NONE;
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_RUN: begin
                if (EX_flush) begin
                    act = ACT_FLUSH;
                end else if (ID_isMulDiv) begin
                    cnt_nxt   = MD_CNT_INIT;
                    state_nxt = ST_MD_WAIT;
                end else if (lu_hit) begin
                    act = ACT_STALL;
                    if (LOAD_STALL_CYCLES > 1) begin
                        cnt_nxt   = LD_CNT_INIT;
                        state_nxt = ST_LD_STALL;
                    end
                end
            end
            ST_LD_STALL: begin
                if (EX_flush) begin
                    act       = ACT_FLUSH;
                    cnt_nxt   = 8'd0;
                    state_nxt = ST_RUN;
                end else begin
                    act = ACT_STALL;
                    if (cnt <= 8'd1) begin
                        cnt_nxt   = 8'd0;
                        state_nxt = ST_RUN;
                    end else begin
                        cnt_nxt = cnt - 8'd1;
                    end
                end
            end
            ST_MD_WAIT: begin
                // The mult/div is older than any branch, so a flush does not cancel it.
                if (EX_flush) begin
                    act = ACT_FLUSH;
                end else if (ID_isMulDiv || ID_useHiLo || lu_hit) begin
                    act = ACT_STALL;
                end
                if (cnt <= 8'd1) begin
                    cnt_nxt   = 8'd0;
                    state_nxt = ST_RUN;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: begin
                cnt_nxt   = 8'd0;
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Output decode; reset overrides everything with a squash-all, hold-PC pattern.
    always_comb begin
        pc_write    = 1'b1;
        IF_ID_sleep = 1'b0;
        IF_ID_nop   = 1'b0;
        ID_EX_nop   = 1'b0;
        md_busy     = 1'b0;
        if (!rst) begin
            pc_write  = 1'b0;
            IF_ID_nop = 1'b1;
            ID_EX_nop = 1'b1;
        end else begin
            md_busy = (state == ST_MD_WAIT);
            case (act)
                ACT_STALL: begin
                    pc_write    = 1'b0;
                    IF_ID_sleep = 1'b1;
                    ID_EX_nop   = 1'b1;
                end
                ACT_FLUSH: begin
                    IF_ID_nop = 1'b1;
                    ID_EX_nop = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_RUN;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef HAZARD_PERF_EN
    // Free-running wrap-around counters of stall cycles and flush events.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= 32'd0;
            flush_count  <= 32'd0;
        end else begin
            if (!pc_write) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (EX_flush) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: two instances (default parameters and
// LOAD_STALL_CYCLES=3 / MULDIV_CYCLES=5) driven with shared stimulus and
// compared every cycle against a counter-based reference model.
module tb_hazard_ctrl;

    // Expected output vector {pc_write, IF_ID_sleep, IF_ID_nop, ID_EX_nop, md_busy}
    localparam logic [4:0] E_RST   = 5'b00110;
    localparam logic [4:0] E_STALL = 5'b01010;
    localparam logic [4:0] E_FLUSH = 5'b10110;
    localparam logic [4:0] E_DEF   = 5'b10000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] ID_rs = '0;
    logic [4:0] ID_rt = '0;
    logic       ID_isMulDiv = 1'b0;
    logic       ID_useHiLo = 1'b0;
    logic       EX_memRead = 1'b0;
    logic [4:0] EX_rt = '0;
    logic       EX_flush = 1'b0;

    logic pc_write_a, IF_ID_sleep_a, IF_ID_nop_a, ID_EX_nop_a, md_busy_a;
    logic pc_write_b, IF_ID_sleep_b, IF_ID_nop_b, ID_EX_nop_b, md_busy_b;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_a, flush_count_a, stall_cycles_b, flush_count_b;
    logic [31:0] stall_m [2];
    logic [31:0] flush_m [2];
`endif

    logic [4:0] obs_a, obs_b, exp_a, exp_b;
    int md_left [2];
    int ld_left [2];
    int checks = 0;
    int errors = 0;

    assign obs_a = {pc_write_a, IF_ID_sleep_a, IF_ID_nop_a, ID_EX_nop_a, md_busy_a};
    assign obs_b = {pc_write_b, IF_ID_sleep_b, IF_ID_nop_b, ID_EX_nop_b, md_busy_b};

    always #5 clk = ~clk;

    hazard_ctrl dut_a (
        .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_isMulDiv(ID_isMulDiv), .ID_useHiLo(ID_useHiLo),
        .EX_memRead(EX_memRead), .EX_rt(EX_rt), .EX_flush(EX_flush),
        .pc_write(pc_write_a), .IF_ID_sleep(IF_ID_sleep_a), .IF_ID_nop(IF_ID_nop_a),
        .ID_EX_nop(ID_EX_nop_a), .md_busy(md_busy_a)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall_cycles_a), .flush_count(flush_count_a)
`endif
    );

    hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MULDIV_CYCLES(5)) dut_b (
        .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_isMulDiv(ID_isMulDiv), .ID_useHiLo(ID_useHiLo),
        .EX_memRead(EX_memRead), .EX_rt(EX_rt), .EX_flush(EX_flush),
        .pc_write(pc_write_b), .IF_ID_sleep(IF_ID_sleep_b), .IF_ID_nop(IF_ID_nop_b),
        .ID_EX_nop(ID_EX_nop_b), .md_busy(md_busy_b)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(stall_cycles_b), .flush_count(flush_count_b)
`endif
    );

    // Reference model: remaining mult/div occupancy and remaining extra load bubbles.
    task automatic model_step(input int k, input int lsc, input int mdc, output logic [4:0] e);
        logic lu;
        lu = EX_memRead && (EX_rt != 0) && (EX_rt == ID_rs || EX_rt == ID_rt);
        if (!rst) begin
            e = E_RST;
            md_left[k] = 0;
            ld_left[k] = 0;
        end else if (md_left[k] > 0) begin
            if (EX_flush) e = E_FLUSH | 5'b00001;
            else if (ID_isMulDiv || ID_useHiLo || lu) e = E_STALL | 5'b00001;
            else e = E_DEF | 5'b00001;
            md_left[k] = md_left[k] - 1;
        end else if (ld_left[k] > 0) begin
            if (EX_flush) begin
                e = E_FLUSH;
                ld_left[k] = 0;
            end else begin
                e = E_STALL;
                ld_left[k] = ld_left[k] - 1;
            end
        end else begin
            if (EX_flush) e = E_FLUSH;
            else if (ID_isMulDiv) begin
                e = E_DEF;
                md_left[k] = mdc;
            end else if (lu) begin
                e = E_STALL;
                ld_left[k] = lsc - 1;
            end else e = E_DEF;
        end
`ifdef HAZARD_PERF_EN
        if (!rst) begin
            stall_m[k] = 0;
            flush_m[k] = 0;
        end else begin
            if (e[4] == 1'b0) stall_m[k] = stall_m[k] + 1;
            if (EX_flush) flush_m[k] = flush_m[k] + 1;
        end
`endif
    endtask

    // Drive one cycle of inputs after the falling edge and compute expectations.
    task automatic apply(input logic r, input logic md, input logic hl, input logic mr,
                         input logic fl, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] ert);
        @(negedge clk);
        rst = r; ID_isMulDiv = md; ID_useHiLo = hl; EX_memRead = mr;
        EX_flush = fl; ID_rs = rs; ID_rt = rt; EX_rt = ert;
        #2;
        model_step(0, 1, 8, exp_a);
        model_step(1, 3, 5, exp_b);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd5);
            checks++;
            if (obs_a !== E_RST) begin errors++; $display("FAIL reset_a cyc %0d got %b exp %b", i, obs_a, E_RST); end
            checks++;
            if (obs_b !== E_RST) begin errors++; $display("FAIL reset_b cyc %0d got %b exp %b", i, obs_b, E_RST); end
        end
    endtask

    task automatic test_load_use();
        int stalls_a = 0;
        int stalls_b = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 5'd2, 5'd5);
            else        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
            if (!pc_write_a) stalls_a++;
            if (!pc_write_b) stalls_b++;
            checks++;
            if (obs_a !== exp_a) begin errors++; $display("FAIL load_use_a cyc %0d got %b exp %b", i, obs_a, exp_a); end
            checks++;
            if (obs_b !== exp_b) begin errors++; $display("FAIL load_use_b cyc %0d got %b exp %b", i, obs_b, exp_b); end
        end
        checks++;
        if (stalls_a != 1) begin errors++; $display("FAIL load_use_len_a got %0d exp 1", stalls_a); end
        checks++;
        if (stalls_b != 3) begin errors++; $display("FAIL load_use_len_b got %0d exp 3", stalls_b); end
    endtask

    task automatic test_rt_zero();
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (obs_a !== E_DEF) begin errors++; $display("FAIL rt_zero_a got %b exp %b", obs_a, E_DEF); end
        checks++;
        if (obs_b !== E_DEF) begin errors++; $display("FAIL rt_zero_b got %b exp %b", obs_b, E_DEF); end
    endtask

    task automatic test_muldiv();
        int busy_a = 0;
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0);
        checks++;
        if (obs_a !== E_DEF) begin errors++; $display("FAIL md_issue_a got %b exp %b", obs_a, E_DEF); end
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
            if (md_busy_a) busy_a++;
            checks++;
            if (obs_a !== exp_a) begin errors++; $display("FAIL md_hilo_a cyc %0d got %b exp %b", i, obs_a, exp_a); end
            checks++;
            if (obs_b !== exp_b) begin errors++; $display("FAIL md_hilo_b cyc %0d got %b exp %b", i, obs_b, exp_b); end
            if (i == 8) begin
                checks++;
                if (obs_a !== E_DEF) begin errors++; $display("FAIL md_first_run_a got %b exp %b", obs_a, E_DEF); end
            end
        end
        checks++;
        if (busy_a != 8) begin errors++; $display("FAIL md_busy_len_a got %0d exp 8", busy_a); end
    endtask

    task automatic test_flush();
        // Flush wins over a simultaneous load-use in RUN.
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 5'd0, 5'd7);
        checks++;
        if (obs_a !== E_FLUSH) begin errors++; $display("FAIL flush_lu_a got %b exp %b", obs_a, E_FLUSH); end
        checks++;
        if (obs_b !== E_FLUSH) begin errors++; $display("FAIL flush_lu_b got %b exp %b", obs_b, E_FLUSH); end
        // Enter LD_STALL on dut_b, then flush in its first cycle.
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd9, 5'd9);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
        checks++;
        if (obs_b !== E_FLUSH) begin errors++; $display("FAIL flush_ld_b got %b exp %b", obs_b, E_FLUSH); end
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (obs_b !== E_DEF) begin errors++; $display("FAIL flush_ld_after_b got %b exp %b", obs_b, E_DEF); end
        checks++;
        if (obs_a !== exp_a) begin errors++; $display("FAIL flush_after_a got %b exp %b", obs_a, exp_a); end
    endtask

    task automatic test_reset_mid();
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 4; i++) apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (obs_a !== E_RST) begin errors++; $display("FAIL reset_mid_a got %b exp %b", obs_a, E_RST); end
        checks++;
        if (obs_b !== E_RST) begin errors++; $display("FAIL reset_mid_b got %b exp %b", obs_b, E_RST); end
        apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        checks++;
        if (obs_a !== E_DEF) begin errors++; $display("FAIL reset_release_a got %b exp %b", obs_a, E_DEF); end
        checks++;
        if (obs_b !== E_DEF) begin errors++; $display("FAIL reset_release_b got %b exp %b", obs_b, E_DEF); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(31) != 0), ($urandom_range(9) == 0), ($urandom_range(5) == 0),
                  ($urandom_range(1) == 0), ($urandom_range(7) == 0),
                  5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)));
            checks++;
            if (obs_a !== exp_a) begin errors++; $display("FAIL random_a cyc %0d got %b exp %b", i, obs_a, exp_a); end
            checks++;
            if (obs_b !== exp_b) begin errors++; $display("FAIL random_b cyc %0d got %b exp %b", i, obs_b, exp_b); end
            checks++;
            if ((IF_ID_sleep_a && IF_ID_nop_a) || (IF_ID_sleep_b && IF_ID_nop_b)) begin
                errors++;
                $display("FAIL sleep_nop_excl cyc %0d got a=%b b=%b exp not both", i, obs_a, obs_b);
            end
        end
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        @(negedge clk);
        checks++;
        if (stall_cycles_a !== stall_m[0]) begin errors++; $display("FAIL perf_stall_a got %0d exp %0d", stall_cycles_a, stall_m[0]); end
        checks++;
        if (flush_count_a !== flush_m[0]) begin errors++; $display("FAIL perf_flush_a got %0d exp %0d", flush_count_a, flush_m[0]); end
        checks++;
        if (stall_cycles_b !== stall_m[1]) begin errors++; $display("FAIL perf_stall_b got %0d exp %0d", stall_cycles_b, stall_m[1]); end
        checks++;
        if (flush_count_b !== flush_m[1]) begin errors++; $display("FAIL perf_flush_b got %0d exp %0d", flush_count_b, flush_m[1]); end
    endtask
`endif

    initial begin
        md_left[0] = 0; md_left[1] = 0;
        ld_left[0] = 0; ld_left[1] = 0;
`ifdef HAZARD_PERF_EN
        stall_m[0] = 0; stall_m[1] = 0;
        flush_m[0] = 0; flush_m[1] = 0;
`endif
        test_reset();
        test_load_use();
        test_rt_zero();
        test_muldiv();
        test_flush();
        test_reset_mid();
        test_random();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
